cbf_window_buf: RTL
===================

# cbf_window_buf

Parametrised control-sample window buffer for the control-bounded FIR path. Accepts one N-bit control sample per handshake, keeps the most recent LOOKAHEAD+LOOKBACK samples, and presents the lookahead and lookback windows to the LUT/FPU accumulation stage once per OSR accepted samples. Successor to the fixed free-running input stage: it adds decimation phase tracking, fill tracking and valid/ready backpressure.

## Interface
- N, 3, control-signal channels (bits per sample)
- LOOKAHEAD, 220, samples newer than the estimate point
- LOOKBACK, 220, samples at or older than the estimate point
- OSR, 1, decimation ratio (≥1); one window strobe per OSR accepted samples
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in  input  N  control sample
- in_valid  input  1  `in` is valid
- in_ready  output  1  buffer can accept; `= !out_valid || out_ready`
- out_ahead  output  N*LOOKAHEAD  lookahead window
- out_back  output  N*LOOKBACK  lookback window
- out_valid  output  1  windows hold a decimated estimate point
- out_ready  input  1  downstream consumes the window
- fill  output  $clog2(W+1)  accepted samples held, saturating at W = LOOKAHEAD+LOOKBACK

## Operation
- Storage: shift register s[0..W-1], s[0] newest. On accept (`in_valid && in_ready`): s[i] <= s[i-1], s[0] <= in.
- Window mapping: out_ahead[N*k +: N] = s[LOOKAHEAD-1-k]; out_back[N*k +: N] = s[LOOKAHEAD+k]; k=0 is nearest the estimate point in both.
- Phase counter 0..OSR-1, increments per accept, wraps to 0; a group completes on the accept where phase == OSR-1. Phase counts from reset regardless of fill.
- Fill counter increments per accept, saturates at W.
- Strobe condition: group completes AND (fill after this accept == W, or CBF_WIN_ZERO_FILL_EN defined).
- out_valid: set on strobe; cleared on `out_valid && out_ready` unless a strobe occurs on the same edge (then stays 1).
- While out_valid && !out_ready: in_ready = 0, windows frozen, phase/fill frozen.
- in_valid low: no state change.

## Timing
- Reset (rst=0, async): s all zero, phase 0, fill 0, out_valid 0, hence in_ready 1, windows all zero.
- Reset deassert is synchronised externally; first accept possible on first rising edge with rst=1.
- Latency: sample accepted at edge t is visible in s[0] and out_valid (if strobing) after edge t; one register stage, no combinational in→out path except in_ready from out_ready.
- OSR=1, out_ready tied 1, W filled: out_valid continuously 1, one window per cycle.
- Reset mid-operation: all state cleared immediately, pending window discarded.
- fill saturates; never wraps.

## Configuration
- CBF_WIN_ZERO_FILL_EN defined: strobes start from the first completed group after reset; unfilled window positions read 0 (reset value).
- Not defined: no strobe until fill == W; first out_valid on the first group completion at or after the W-th accepted sample.

## Test plan
- N=3, LOOKAHEAD=2, LOOKBACK=2, OSR=1, macro off, feed 1,2,3,4,5 with out_ready=1 -> out_valid first 1 after 4th accept with out_ahead={k0:3,k1:4}, out_back={k0:2,k1:1}; after 5th: ahead {4,5}, back {3,2}.
- LOOKAHEAD=4, LOOKBACK=2 (W=6), OSR=4, macro off, continuous input -> strobes after accepts 8, 12, 16; none at 4.
- Same as above, macro on -> strobes after accepts 4, 8, 12; at accept 4 out_back = {0,0}, fill = 4.
- OSR=1, W filled, out_ready held 0 for 3 cycles with in_valid=1 -> in_ready 0, windows and fill unchanged; out_ready=1 -> next sample accepted that edge, out_valid stays 1.
- in_valid toggled 1/0 with OSR=2 -> phase advances only on accepts; strobe every second accepted sample.
- Assert rst=0 mid-stream between edges -> out_valid, fill, windows 0 immediately; in_ready 1; refill behaviour as from power-up.

Source files
------------

// File: rtl/cbf_window_buf.sv
// Control-sample window buffer: shift register with decimation phase, fill tracking and valid/ready.
// Optional macro CBF_WIN_ZERO_FILL_EN: strobe before the buffer is full (unfilled slots read 0).
module cbf_window_buf #(
    parameter  int N         = 3,
    parameter  int LOOKAHEAD = 220,
    parameter  int LOOKBACK  = 220,
    parameter  int OSR       = 1,
    localparam int W         = LOOKAHEAD + LOOKBACK,
    localparam int FW        = $clog2(W + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N*LOOKAHEAD-1:0] out_ahead,
    output logic [N*LOOKBACK-1:0]  out_back,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FW-1:0]          fill
);
    localparam int              PW         = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [PW-1:0]   PHASE_LAST = PW'(OSR - 1);
    localparam logic [FW-1:0]   FILL_FULL  = FW'(W);

    logic [N-1:0]  r_s [W];
    logic [PW-1:0] r_phase;
    logic [FW-1:0] r_fill;
    logic          r_valid;

    logic          w_acc;
    logic          w_group_done;
    logic          w_strobe;
    logic [FW-1:0] w_fill_nxt;

    // A pending window blocks intake so it cannot be overwritten before it is consumed.
    assign in_ready     = !r_valid || out_ready;
    assign w_acc        = in_valid && in_ready;
    assign w_group_done = (r_phase == PHASE_LAST);
    assign w_fill_nxt   = (r_fill == FILL_FULL) ? r_fill : r_fill + FW'(1);

`ifdef CBF_WIN_ZERO_FILL_EN
    assign w_strobe = w_acc && w_group_done;
`else
    assign w_strobe = w_acc && w_group_done && (w_fill_nxt == FILL_FULL);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < W; i++) r_s[i] <= '0;
        end else if (w_acc) begin
            r_s[0] <= in;
            for (int i = 1; i < W; i++) r_s[i] <= r_s[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
            r_fill  <= '0;
        end else if (w_acc) begin
            r_phase <= w_group_done ? '0 : r_phase + PW'(1);
            r_fill  <= w_fill_nxt;
        end
    end

    // A strobe on the consuming edge keeps valid high so back-to-back windows have no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (w_strobe) begin
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < LOOKAHEAD; k++) begin : g_ahead
        assign out_ahead[N*k +: N] = r_s[LOOKAHEAD-1-k];
    end

    for (genvar k = 0; k < LOOKBACK; k++) begin : g_back
        assign out_back[N*k +: N] = r_s[LOOKAHEAD+k];
    end

    assign out_valid = r_valid;
    assign fill      = r_fill;

endmodule
